// File: rtl/serving_ram_arb.sv
// Arbitrates the single byte-wide 1R1W SRAM between the serving core port and a
// host load/debug port; core traffic passes straight through, host accesses slot in.
module serving_ram_arb #(
    parameter int AW           = 10,
    parameter int DW           = 8,
    parameter int STARVE_LIMIT = 64
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [AW-1:0] i_core_waddr,
    input  logic [DW-1:0] i_core_wdata,
    input  logic          i_core_wen,
    input  logic [AW-1:0] i_core_raddr,
    input  logic          i_core_ren,
    output logic [DW-1:0] o_core_rdata,
    input  logic          i_core_halted,
    output logic          o_core_hold,
    input  logic          i_ext_req,
    input  logic          i_ext_we,
    input  logic [AW-1:0] i_ext_adr,
    input  logic [DW-1:0] i_ext_wdat,
    output logic          o_ext_busy,
    output logic          o_ext_ack,
    output logic [DW-1:0] o_ext_rdt,
    output logic [AW-1:0] o_sram_waddr,
    output logic [DW-1:0] o_sram_wdata,
    output logic          o_sram_wen,
    output logic [AW-1:0] o_sram_raddr,
    output logic          o_sram_ren,
    input  logic [DW-1:0] i_sram_rdata
);

    localparam int            CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    // state | meaning
    // IDLE  | no host request held, new requests accepted
    // PEND  | host request held, waiting for its SRAM port
    // RDATA | host read issued, SRAM data arrives this cycle
    // DONE  | host access complete, ack pulse
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PEND  = 2'd1,
        S_RDATA = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_we;
    logic [AW-1:0] r_adr;
    logic [DW-1:0] r_wdat;
    logic [DW-1:0] r_rdt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_hold;
    logic          w_hold_nxt;
    logic          w_wport_free;
    logic          w_rport_free;
    logic          w_issue_w;
    logic          w_issue_r;
    logic          w_issue;
    logic          w_capture;
    logic          w_core_wen;
    logic          w_core_ren;

    // A halted core has its whole port ignored, so both SRAM ports are free.
    assign w_core_wen   = i_core_wen & ~i_core_halted;
    assign w_core_ren   = i_core_ren & ~i_core_halted;
    assign w_wport_free = ~w_core_wen;
    assign w_rport_free = ~w_core_ren;

    always_comb begin
        w_state_nxt = r_state;
        w_issue_w   = 1'b0;
        w_issue_r   = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_ext_req) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_PEND;
                end
            end
            S_PEND: begin
                if (r_we && w_wport_free) begin
                    w_issue_w   = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (!r_we && w_rport_free) begin
                    w_issue_r   = 1'b1;
                    w_state_nxt = S_RDATA;
                end
            end
            S_RDATA: w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_issue = w_issue_w | w_issue_r;

    // Counter saturates at the limit, so hold stays up until the access issues.
    always_comb begin
        w_cnt_nxt  = '0;
        w_hold_nxt = 1'b0;
        if (r_state == S_PEND && !w_issue) begin
            w_cnt_nxt  = (r_cnt == LIMIT) ? r_cnt : r_cnt + CW'(1);
            w_hold_nxt = (w_cnt_nxt == LIMIT);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_wdat  <= '0;
            r_rdt   <= '0;
            r_cnt   <= '0;
            r_hold  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hold  <= w_hold_nxt;
            if (w_capture) begin
                r_we   <= i_ext_we;
                r_adr  <= i_ext_adr;
                r_wdat <= i_ext_wdat;
            end
            if (r_state == S_RDATA) begin
                r_rdt <= i_sram_rdata;
            end
        end
    end

    // Addresses and data follow the core unless the host owns the port this cycle.
    assign o_sram_wen   = w_issue_w | w_core_wen;
    assign o_sram_waddr = w_issue_w ? r_adr  : i_core_waddr;
    assign o_sram_wdata = w_issue_w ? r_wdat : i_core_wdata;
    assign o_sram_ren   = w_issue_r | w_core_ren;
    assign o_sram_raddr = w_issue_r ? r_adr  : i_core_raddr;

    assign o_core_rdata = i_sram_rdata;
    assign o_core_hold  = r_hold;
    assign o_ext_busy   = (r_state != S_IDLE);
    assign o_ext_ack    = (r_state == S_DONE);
    assign o_ext_rdt    = r_rdt;

endmodule

// File: tb/tb_serving_ram_arb.sv
// Bench for serving_ram_arb: core pass-through vectors, host access sequences and
// random traffic compared against a transaction-level model with a reference memory.
module tb_serving_ram_arb;

    localparam int AW  = 10;
    localparam int DW  = 8;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] core_waddr = '0;
    logic [DW-1:0] core_wdata = '0;
    logic          core_wen = 1'b0;
    logic [AW-1:0] core_raddr = '0;
    logic          core_ren = 1'b0;
    logic          core_halted = 1'b0;
    logic          ext_req = 1'b0;
    logic          ext_we = 1'b0;
    logic [AW-1:0] ext_adr = '0;
    logic [DW-1:0] ext_wdat = '0;
    logic [DW-1:0] sram_rdata = '0;

    logic [DW-1:0] o_core_rdata;
    logic          o_core_hold;
    logic          o_ext_busy;
    logic          o_ext_ack;
    logic [DW-1:0] o_ext_rdt;
    logic [AW-1:0] o_sram_waddr;
    logic [DW-1:0] o_sram_wdata;
    logic          o_sram_wen;
    logic [AW-1:0] o_sram_raddr;
    logic          o_sram_ren;

    always #5 clk = ~clk;

    serving_ram_arb #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_core_waddr (core_waddr),
        .i_core_wdata (core_wdata),
        .i_core_wen   (core_wen),
        .i_core_raddr (core_raddr),
        .i_core_ren   (core_ren),
        .o_core_rdata (o_core_rdata),
        .i_core_halted(core_halted),
        .o_core_hold  (o_core_hold),
        .i_ext_req    (ext_req),
        .i_ext_we     (ext_we),
        .i_ext_adr    (ext_adr),
        .i_ext_wdat   (ext_wdat),
        .o_ext_busy   (o_ext_busy),
        .o_ext_ack    (o_ext_ack),
        .o_ext_rdt    (o_ext_rdt),
        .o_sram_waddr (o_sram_waddr),
        .o_sram_wdata (o_sram_wdata),
        .o_sram_wen   (o_sram_wen),
        .o_sram_raddr (o_sram_raddr),
        .o_sram_ren   (o_sram_ren),
        .i_sram_rdata (sram_rdata)
    );

    // SRAM behavioural model driven by the DUT
    logic [DW-1:0] sram [0:(1<<AW)-1] = '{default: '0};
    always @(posedge clk) begin
        if (o_sram_wen) sram[o_sram_waddr] <= o_sram_wdata;
        if (o_sram_ren) sram_rdata <= sram[o_sram_raddr];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one host transaction tracked by cycles since issue
    logic [DW-1:0] ref_mem [0:(1<<AW)-1] = '{default: '0};
    bit            m_busy = 0;
    bit            m_we = 0;
    logic [AW-1:0] m_adr = '0;
    logic [DW-1:0] m_wdat = '0;
    int            m_since = -1;
    int            m_wait = 0;
    logic [DW-1:0] m_rval = '0;
    logic [DW-1:0] exp_rdt = '0;
    logic [DW-1:0] exp_rd = '0;

    bit            e_issue, e_iw, e_ir, e_wen, e_ren, e_ack;
    logic [AW-1:0] e_waddr, e_raddr;
    logic [DW-1:0] e_wdata;

    task automatic check_outputs();
        bit wfree, rfree;
        wfree   = !core_wen || core_halted;
        rfree   = !core_ren || core_halted;
        e_issue = m_busy && m_since < 0 && (m_we ? wfree : rfree);
        e_iw    = e_issue && m_we;
        e_ir    = e_issue && !m_we;
        e_wen   = e_iw || (core_wen && !core_halted);
        e_ren   = e_ir || (core_ren && !core_halted);
        e_waddr = e_iw ? m_adr : core_waddr;
        e_wdata = e_iw ? m_wdat : core_wdata;
        e_raddr = e_ir ? m_adr : core_raddr;
        e_ack   = m_busy && ((m_we && m_since == 1) || (!m_we && m_since == 2));
        chk("sram_wen", o_sram_wen, e_wen);
        chk("sram_ren", o_sram_ren, e_ren);
        chk("sram_waddr", o_sram_waddr, e_waddr);
        chk("sram_wdata", o_sram_wdata, e_wdata);
        chk("sram_raddr", o_sram_raddr, e_raddr);
        chk("ext_busy", o_ext_busy, m_busy);
        chk("ext_ack", o_ext_ack, e_ack);
        chk("ext_rdt", o_ext_rdt, exp_rdt);
        chk("core_hold", o_core_hold, m_busy && m_since < 0 && m_wait >= LIM);
        chk("core_rdata", o_core_rdata, exp_rd);
    endtask

    task automatic model_update();
        logic [DW-1:0] rd;
        rd = ref_mem[e_raddr];
        if (e_ren) exp_rd = rd;
        if (e_wen) ref_mem[e_waddr] = e_wdata;
        if (e_ack) begin
            m_busy  = 0;
            m_since = -1;
            m_wait  = 0;
        end else if (m_busy) begin
            if (m_since >= 1) begin
                if (!m_we && m_since == 1) exp_rdt = m_rval;
                m_since++;
            end else if (e_issue) begin
                m_since = 1;
                m_wait  = 0;
                if (e_ir) m_rval = rd;
            end else if (m_wait < LIM) begin
                m_wait++;
            end
        end else if (ext_req && rst_n) begin
            m_busy  = 1;
            m_we    = ext_we;
            m_adr   = ext_adr;
            m_wdat  = ext_wdat;
            m_since = -1;
            m_wait  = 0;
        end
    endtask

    task automatic model_reset();
        m_busy  = 0;
        m_since = -1;
        m_wait  = 0;
        exp_rdt = '0;
    endtask

    task automatic sample();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    typedef struct {
        logic          wen;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic          ren;
        logic [AW-1:0] raddr;
        logic          halted;
        logic          x_wen;
        logic          x_ren;
        logic [AW-1:0] x_waddr;
        logic [DW-1:0] x_wdata;
        logic [AW-1:0] x_raddr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int k;
        bit found;
        int acks, writes;

        vecs[0] = '{1'b1, 10'h012, 8'h3C, 1'b0, 10'h020, 1'b0, 1'b1, 1'b0, 10'h012, 8'h3C, 10'h020};
        vecs[1] = '{1'b0, 10'h013, 8'h11, 1'b1, 10'h012, 1'b0, 1'b0, 1'b1, 10'h013, 8'h11, 10'h012};
        vecs[2] = '{1'b1, 10'h3FF, 8'hFF, 1'b1, 10'h000, 1'b0, 1'b1, 1'b1, 10'h3FF, 8'hFF, 10'h000};
        vecs[3] = '{1'b1, 10'h001, 8'h77, 1'b1, 10'h002, 1'b1, 1'b0, 1'b0, 10'h001, 8'h77, 10'h002};
        vecs[4] = '{1'b0, 10'h100, 8'h00, 1'b0, 10'h101, 1'b0, 1'b0, 1'b0, 10'h100, 8'h00, 10'h101};
        vecs[5] = '{1'b1, 10'h200, 8'h5A, 1'b1, 10'h3FF, 1'b0, 1'b1, 1'b1, 10'h200, 8'h5A, 10'h3FF};

        // Reset values
        #1;
        chk("rst_busy", o_ext_busy, 1'b0);
        chk("rst_ack", o_ext_ack, 1'b0);
        chk("rst_hold", o_core_hold, 1'b0);
        chk("rst_rdt", o_ext_rdt, 8'h00);
        chk("rst_wen", o_sram_wen, 1'b0);
        chk("rst_ren", o_sram_ren, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;

        // Core-only pass-through vectors
        for (int i = 0; i < 6; i++) begin
            core_wen    = vecs[i].wen;
            core_waddr  = vecs[i].waddr;
            core_wdata  = vecs[i].wdata;
            core_ren    = vecs[i].ren;
            core_raddr  = vecs[i].raddr;
            core_halted = vecs[i].halted;
            sample();
            chk("vec_wen", o_sram_wen, vecs[i].x_wen);
            chk("vec_ren", o_sram_ren, vecs[i].x_ren);
            chk("vec_waddr", o_sram_waddr, vecs[i].x_waddr);
            chk("vec_wdata", o_sram_wdata, vecs[i].x_wdata);
            chk("vec_raddr", o_sram_raddr, vecs[i].x_raddr);
            chk("vec_ack", o_ext_ack, 1'b0);
            advance();
        end
        core_wen = 0; core_ren = 0; core_halted = 0;
        tick();

        // Host write 0x155 <= 0xA5, core idle
        ext_req = 1; ext_we = 1; ext_adr = 10'h155; ext_wdat = 8'hA5;
        sample();
        chk("wr_busy_n", o_ext_busy, 1'b0);
        advance();
        ext_req = 0;
        sample();
        chk("wr_issue_wen", o_sram_wen, 1'b1);
        chk("wr_issue_addr", o_sram_waddr, 10'h155);
        chk("wr_issue_data", o_sram_wdata, 8'hA5);
        chk("wr_busy_n1", o_ext_busy, 1'b1);
        advance();
        sample();
        chk("wr_ack_n2", o_ext_ack, 1'b1);
        chk("wr_busy_n2", o_ext_busy, 1'b1);
        advance();
        sample();
        chk("wr_busy_n3", o_ext_busy, 1'b0);
        chk("wr_ack_n3", o_ext_ack, 1'b0);
        advance();

        // Host read of 0x155 while core reads 0x012 for three cycles
        core_ren = 1; core_raddr = 10'h012;
        ext_req = 1; ext_we = 0; ext_adr = 10'h155;
        tick();
        ext_req = 0;
        found = 0;
        for (k = 1; k <= 12; k++) begin
            core_ren = (k < 3);
            sample();
            if (k < 3) chk("rd_core_raddr", o_sram_raddr, 10'h012);
            if (k == 3) begin
                chk("rd_issue_ren", o_sram_ren, 1'b1);
                chk("rd_issue_addr", o_sram_raddr, 10'h155);
            end
            if (o_ext_ack === 1'b1) begin
                chk("rd_ack_delay", k, 5);
                chk("rd_rdt", o_ext_rdt, 8'hA5);
                found = 1;
            end
            advance();
            if (found) break;
        end
        if (!found) chk("rd_ack_timeout", 0, 1);
        core_ren = 0;
        tick();

        // Starvation: core writing continuously, host write pending
        core_wen = 1; core_waddr = 10'h030; core_wdata = 8'h12;
        ext_req = 1; ext_we = 1; ext_adr = 10'h040; ext_wdat = 8'h66;
        tick();
        ext_req = 0;
        found = 0;
        for (k = 1; k <= 20; k++) begin
            sample();
            if (o_core_hold === 1'b1) begin
                chk("hold_delay", k, LIM + 1);
                found = 1;
            end
            advance();
            if (found) break;
        end
        if (!found) chk("hold_timeout", 0, 1);
        core_halted = 1;
        sample();
        chk("halt_issue_wen", o_sram_wen, 1'b1);
        chk("halt_issue_addr", o_sram_waddr, 10'h040);
        chk("halt_hold_still", o_core_hold, 1'b1);
        advance();
        sample();
        chk("halt_hold_clr", o_core_hold, 1'b0);
        chk("halt_ack", o_ext_ack, 1'b1);
        advance();
        core_halted = 0; core_wen = 0;
        tick();

        // Reset while a host request is pending
        core_wen = 1;
        ext_req = 1; ext_we = 1; ext_adr = 10'h077; ext_wdat = 8'hEE;
        tick();
        ext_req = 0;
        tick();
        rst_n = 0;
        #1;
        chk("mid_rst_busy", o_ext_busy, 1'b0);
        chk("mid_rst_ack", o_ext_ack, 1'b0);
        chk("mid_rst_rdt", o_ext_rdt, 8'h00);
        chk("mid_rst_hold", o_core_hold, 1'b0);
        model_reset();
        tick();
        rst_n = 1;
        core_wen = 0;
        ext_req = 1; ext_we = 1; ext_adr = 10'h078; ext_wdat = 8'h3D;
        tick();
        ext_req = 0;
        acks = 0;
        for (k = 0; k < 6; k++) begin
            sample();
            if (o_ext_ack === 1'b1) acks++;
            advance();
        end
        chk("post_rst_acks", acks, 1);

        // Repeated request while busy, held through the DONE cycle
        ext_req = 1; ext_we = 1; ext_adr = 10'h0AA; ext_wdat = 8'h33;
        acks = 0; writes = 0;
        for (k = 0; k < 8; k++) begin
            ext_req = (k < 3);
            sample();
            if (o_ext_ack === 1'b1) acks++;
            if (o_sram_wen === 1'b1) writes++;
            advance();
        end
        chk("dbl_acks", acks, 1);
        chk("dbl_writes", writes, 1);

        // Random traffic against the model
        for (int c = 0; c < 800; c++) begin
            core_wen   = ($urandom_range(0, 1) == 1);
            core_ren   = ($urandom_range(0, 1) == 1);
            core_waddr = AW'($urandom_range(0, 31));
            core_raddr = AW'($urandom_range(0, 31));
            core_wdata = DW'($urandom);
            if ($urandom_range(0, 15) == 0) core_halted = ~core_halted;
            ext_req  = ($urandom_range(0, 2) == 0);
            ext_we   = ($urandom_range(0, 1) == 1);
            ext_adr  = AW'($urandom_range(0, 31));
            ext_wdat = DW'($urandom);
            tick();
        end
        ext_req = 0; core_wen = 0; core_ren = 0; core_halted = 0;
        for (int c = 0; c < 12; c++) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serving_ram_arb.md
# serving_ram_arb

Shares the serving SoC's single byte-wide 1R1W SRAM between the core-side register-file/memory port (from `servile_rf_mem_if`) and an external host port used for program loading and debug, replacing static select-line muxing. Core accesses always pass straight through with zero added latency. A host request is held in a one-entry request register and issued in the first cycle the needed SRAM port is idle, or unconditionally while the core is halted. A starvation counter raises a hold request to the core controller when a host request has waited too long.

## Interface
- `AW`, 10, SRAM address width (`$clog2(memsize)`)
- `DW`, 8, SRAM data width (`rf_width`)
- `STARVE_LIMIT`, 64, cycles a host request waits in PEND before `o_core_hold` asserts; legal range 1..1023

- `i_clk`  in  1  system clock, all state on rising edge
- `i_rst_n`  in  1  reset, asynchronous assert, active-low
- `i_core_waddr`  in  AW  core write address
- `i_core_wdata`  in  DW  core write data
- `i_core_wen`  in  1  core write enable
- `i_core_raddr`  in  AW  core read address
- `i_core_ren`  in  1  core read enable
- `o_core_rdata`  out  DW  read data to core, equal to `i_sram_rdata`
- `i_core_halted`  in  1  core is stopped; its port is ignored
- `o_core_hold`  out  1  request to stall/halt the core (starvation)
- `i_ext_req`  in  1  host request strobe
- `i_ext_we`  in  1  host request is a write (1) or a read (0)
- `i_ext_adr`  in  AW  host address
- `i_ext_wdat`  in  DW  host write data
- `o_ext_busy`  out  1  request register occupied; new requests are ignored
- `o_ext_ack`  out  1  single-cycle completion pulse
- `o_ext_rdt`  out  DW  host read data, valid from the ack cycle, held until the next read ack
- `o_sram_waddr`, `o_sram_wdata`, `o_sram_wen`, `o_sram_raddr`, `o_sram_ren`  out  AW/DW/1/AW/1  SRAM control
- `i_sram_rdata`  in  DW  SRAM read data, one cycle after `o_sram_ren`

## Operation
- Write-port ownership:
  - Free when `i_core_wen==0` or `i_core_halted==1`.
  - Otherwise the core owns it and the core signals pass through.
- Read-port ownership:
  - Free when `i_core_ren==0` or `i_core_halted==1`.
- Halted core: when `i_core_halted==1`, all core inputs are ignored. The SRAM is driven only by a host access; otherwise `wen` and `ren` are 0.
- Idle SRAM outputs: when no one is issuing, the address and data outputs still follow the core inputs.
- FSM states and transitions:
  - IDLE: `o_ext_busy=0`. If `i_ext_req`, capture `we`, `adr` and `wdat`, then go to PEND.
  - PEND, write with write port free: drive `o_sram_wen=1`, `waddr=adr`, `wdata=wdat` this cycle, then go to DONE.
  - PEND, read with read port free: drive `o_sram_ren=1`, `raddr=adr`, then go to RDATA.
  - PEND, port not free: stay in PEND.
  - RDATA: register `i_sram_rdata` into `o_ext_rdt`, then go to DONE.
  - DONE: `o_ext_ack=1`, then go to IDLE.
- `o_ext_busy = (state != IDLE)`.
- Starvation counter:
  - Saturating, width `$clog2(STARVE_LIMIT+1)`.
  - Increments each cycle spent in PEND without issuing.
  - Clears on leaving PEND.
- `o_core_hold`:
  - Registered; set when the counter reaches `STARVE_LIMIT`.
  - Cleared on the cycle the host access issues.
  - The arbiter never preempts the core itself. Issue still requires a free port or `i_core_halted`.
- `o_core_rdata` is a wire from `i_sram_rdata`. After a host read, the core sees host data only in a cycle following its own `ren==0`, which it does not consume.
- Reads and writes use independent ports. A host read may issue while the core writes, and a host write may issue while the core reads.

## Timing
- Reset (`i_rst_n=0`, asynchronous, including mid-request):
  - State IDLE, counter 0.
  - `o_ext_busy`, `o_ext_ack`, `o_core_hold` = 0; `o_ext_rdt` = 0.
  - A pending or in-flight host access is dropped with no ack.
  - SRAM enables are 0 unless the core drives them.
- Host write latency, best case: req at cycle N, issue N+1, ack N+2, new request accepted N+3.
- Host read latency, best case: req N, issue N+1, data registered at end of N+2, ack with valid `o_ext_rdt` at N+3.
- Each cycle of core use on the required port adds one cycle.
- `i_ext_req` is sampled only in IDLE. Requests while busy are lost, and the host must wait for ack.
- A req coinciding with the DONE cycle is ignored.
- `i_core_halted` rising while in PEND allows issue in that same cycle.

## Test plan
- Core-only traffic (`ren` and `wen` toggling, `i_ext_req=0`) → SRAM outputs equal core inputs every cycle; `o_core_rdata` follows the SRAM; no ack.
- Host write `adr=0x155`, `wdat=0xA5` with core idle → `o_sram_wen=1`, `waddr=0x155` at N+1; ack at N+2; busy high for N+1..N+2.
- Host read of 0x155 while core `ren=1` for 3 cycles → issue waits until `ren` drops; ack with `o_ext_rdt=0xA5` two cycles after issue; core reads are unaffected.
- `STARVE_LIMIT=4`, core `wen` held high, host write pending → `o_core_hold` rises after 4 PEND cycles. Then assert `i_core_halted` → issue the same cycle, hold clears, ack follows.
- Host request pending, `i_rst_n` pulsed low → no ack, busy 0 and `o_ext_rdt` 0 immediately; a subsequent request completes normally.
- Second `i_ext_req` during busy → ignored, exactly one ack, SRAM written once.
